// File: rtl/mailbox_wb_ctrl_if.sv
// Wishbone-classic slave-side bus bundle for the mailbox controller.
interface mailbox_wb_ctrl_if;
    localparam int unsigned ADR_W  = 2;
    localparam int unsigned DATA_W = 8;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADR_W-1:0]  wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/mailbox_wb_ctrl.sv
// Wishbone slave sequencing the mailbox FIFO pair: clean one-cycle push/pop
// strobes, flush, sticky over/underflow flags and a level interrupt.
module mailbox_wb_ctrl #(
    parameter  int unsigned FLUSH_CYCLES = 2,
    localparam int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    mailbox_wb_ctrl_if.slave  wb,
    output logic              out_write_strobe,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_full,
    input  logic              out_not_empty,
    output logic              in_read_strobe,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_not_empty,
    input  logic              in_full,
    output logic              fifo_flush,
    output logic              irq
);
    localparam int unsigned CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned CLR_BIT   = 6;
    localparam int unsigned FLUSH_BIT = 7;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_STROBE, S_SETTLE, S_ACK, S_FLUSH
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        ctrl_en, ctrl_nxt;
    logic              overflow, ovf_nxt;
    logic              underflow, unf_nxt;
    logic              rd_op, rd_op_nxt;
    logic              abort, abort_nxt;
    logic              out_ws_nxt, in_rs_nxt, flush_nxt, irq_nxt, ack_nxt;
    logic [DATA_W-1:0] out_data_nxt, dat_o_nxt;
    logic [DATA_W-1:0] status_c;

    assign status_c = {2'b00, underflow, overflow, out_full, out_not_empty, in_full, in_not_empty};

    // Next-state and next-output decode
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ctrl_nxt     = ctrl_en;
        ovf_nxt      = overflow;
        unf_nxt      = underflow;
        rd_op_nxt    = rd_op;
        abort_nxt    = abort | ~wb.wb_cyc_i;
        out_ws_nxt   = 1'b0;
        in_rs_nxt    = 1'b0;
        flush_nxt    = 1'b0;
        out_data_nxt = out_data;
        dat_o_nxt    = wb.wb_dat_o;
        irq_nxt      = (ctrl_en[0] & in_not_empty) | (ctrl_en[1] & ~out_full);

        case (state)
            S_IDLE: begin
                abort_nxt = 1'b0;
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    rd_op_nxt = ~wb.wb_we_i;
                    state_nxt = S_ACK;
                    case (wb.wb_adr_i)
                        ADR_DATA: begin
                            if (wb.wb_we_i) begin
                                if (!out_full) begin
                                    out_data_nxt = wb.wb_dat_i;
                                    out_ws_nxt   = 1'b1;
                                    state_nxt    = S_STROBE;
                                end else begin
                                    ovf_nxt = 1'b1;
                                end
                            end else if (in_not_empty) begin
                                in_rs_nxt = 1'b1;
                                state_nxt = S_STROBE;
                            end else begin
                                unf_nxt   = 1'b1;
                                dat_o_nxt = '0;
                            end
                        end
                        ADR_STATUS: begin
                            if (!wb.wb_we_i) dat_o_nxt = status_c;
                        end
                        ADR_CTRL: begin
                            if (wb.wb_we_i) begin
                                ctrl_nxt = wb.wb_dat_i[1:0];
                                if (wb.wb_dat_i[CLR_BIT]) begin
                                    ovf_nxt = 1'b0;
                                    unf_nxt = 1'b0;
                                end
                                if (wb.wb_dat_i[FLUSH_BIT]) begin
                                    flush_nxt = 1'b1;
                                    cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                                    state_nxt = S_FLUSH;
                                end
                            end else begin
                                dat_o_nxt = DATA_W'(ctrl_en);
                            end
                        end
                        default: begin
                            if (!wb.wb_we_i) dat_o_nxt = '0;
                        end
                    endcase
                end
            end
            // Head byte is captured while the pop strobe is high, before it takes effect
            S_STROBE: begin
                if (rd_op) dat_o_nxt = in_data;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: state_nxt = S_ACK;
            S_ACK:    state_nxt = S_IDLE;
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = S_ACK;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    flush_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A master that abandoned its cycle never sees the acknowledge
        ack_nxt = (state_nxt == S_ACK) && !abort_nxt;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ctrl_en          <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            rd_op            <= 1'b0;
            abort            <= 1'b0;
            out_write_strobe <= 1'b0;
            in_read_strobe   <= 1'b0;
            fifo_flush       <= 1'b0;
            irq              <= 1'b0;
            out_data         <= '0;
            wb.wb_dat_o      <= '0;
            wb.wb_ack_o      <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            ctrl_en          <= ctrl_nxt;
            overflow         <= ovf_nxt;
            underflow        <= unf_nxt;
            rd_op            <= rd_op_nxt;
            abort            <= abort_nxt;
            out_write_strobe <= out_ws_nxt;
            in_read_strobe   <= in_rs_nxt;
            fifo_flush       <= flush_nxt;
            irq              <= irq_nxt;
            out_data         <= out_data_nxt;
            wb.wb_dat_o      <= dat_o_nxt;
            wb.wb_ack_o      <= ack_nxt;
        end
    end
endmodule

// File: tb/tb_mailbox_wb_ctrl.sv
// Scoreboard bench for mailbox_wb_ctrl with behavioural 8-deep FIFO models.
module tb_mailbox_wb_ctrl;
    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mailbox_wb_ctrl_if wb();

    logic       out_write_strobe, out_full, out_not_empty;
    logic       in_read_strobe, in_not_empty, in_full;
    logic       fifo_flush, irq;
    logic [7:0] out_data, in_data;

    mailbox_wb_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wb               (wb),
        .out_write_strobe (out_write_strobe),
        .out_data         (out_data),
        .out_full         (out_full),
        .out_not_empty    (out_not_empty),
        .in_read_strobe   (in_read_strobe),
        .in_data          (in_data),
        .in_not_empty     (in_not_empty),
        .in_full          (in_full),
        .fifo_flush       (fifo_flush),
        .irq              (irq)
    );

    // Outbound FIFO occupancy model
    logic [3:0] out_cnt = '0;
    always @(posedge clk) begin
        if (fifo_flush) out_cnt <= '0;
        else if (out_write_strobe && out_cnt < 4'd8) out_cnt <= out_cnt + 4'd1;
    end
    assign out_full      = (out_cnt == 4'd8);
    assign out_not_empty = (out_cnt != 4'd0);

    // Inbound FIFO model, fed by in_push()
    logic [7:0] in_mem [8];
    logic [2:0] in_rd = '0, in_wr = '0;
    logic [3:0] in_cnt = '0;
    logic       in_push_req = 1'b0;
    logic [7:0] in_push_dat = '0;
    logic       do_push, do_pop;
    assign do_push = in_push_req && (in_cnt < 4'd8);
    assign do_pop  = in_read_strobe && (in_cnt != 4'd0);
    always @(posedge clk) begin
        if (fifo_flush) begin
            in_rd <= '0; in_wr <= '0; in_cnt <= '0;
        end else begin
            if (do_push) begin
                in_mem[in_wr] <= in_push_dat;
                in_wr         <= in_wr + 3'd1;
            end
            if (do_pop) in_rd <= in_rd + 3'd1;
            in_cnt <= in_cnt + (do_push ? 4'd1 : 4'd0) - (do_pop ? 4'd1 : 4'd0);
        end
    end
    assign in_data      = in_mem[in_rd];
    assign in_not_empty = (in_cnt != 4'd0);
    assign in_full      = (in_cnt == 4'd8);

    // Monitor: observed strobe/flush events tagged with posedge count
    typedef struct { int n; logic [7:0] d; } wr_ev_t;
    typedef struct { logic [7:0] d; int lat; } exp_t;
    wr_ev_t     wr_log [$];
    int         rd_log [$];
    int         fl_log [$];
    exp_t       exp_q [$];
    logic [7:0] out_exp_q [$];
    int pcnt    = 0;
    int both_hi = 0;
    int checks  = 0;
    int errors  = 0;

    always @(posedge clk) pcnt <= pcnt + 1;
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_write_strobe) wr_log.push_back('{n: pcnt, d: out_data});
            if (in_read_strobe)   rd_log.push_back(pcnt);
            if (fifo_flush)       fl_log.push_back(pcnt);
            if (out_write_strobe && in_read_strobe) both_hi <= both_hi + 1;
        end
    end

    task automatic wb_access(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                             output logic [7:0] rd, output int lat, output int n0);
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr;  wb.wb_dat_i = dat;
        n0 = pcnt; lat = 0; rd = 'x;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (wb.wb_ack_o === 1'b1) begin
                lat = k; rd = wb.wb_dat_o;
                break;
            end
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic in_push(input logic [7:0] b);
        @(negedge clk);
        in_push_req = 1'b1; in_push_dat = b;
        @(negedge clk);
        in_push_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd; int lat, n0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wb.wb_ack_o, out_write_strobe, in_read_strobe, fifo_flush, irq, wb.wb_dat_o, out_data} !== '0) begin
            errors++; $display("FAIL reset_outputs got ack%b ws%b rs%b fl%b irq%b dat%h od%h exp all 0",
                wb.wb_ack_o, out_write_strobe, in_read_strobe, fifo_flush, irq, wb.wb_dat_o, out_data);
        end
        reset_n = 1'b1;
        wb_access(1'b1, ADR_CTRL, 8'h02, rd, lat, n0);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_pre_reset got %b exp 1", irq); end
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = ADR_DATA; wb.wb_dat_i = 8'h99;
        @(posedge clk); #1;
        checks++; if (out_write_strobe !== 1'b1) begin errors++; $display("FAIL strobe_before_reset got %b exp 1", out_write_strobe); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_write_strobe, in_read_strobe, wb.wb_ack_o, irq, fifo_flush} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_strobe got ws%b rs%b ack%b irq%b fl%b exp all 0",
                out_write_strobe, in_read_strobe, wb.wb_ack_o, irq, fifo_flush);
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_write_strobe, wb.wb_ack_o, irq} !== 3'b0) begin
            errors++; $display("FAIL post_reset_quiet got ws%b ack%b irq%b exp 000", out_write_strobe, wb.wb_ack_o, irq);
        end
        wr_log.delete(); rd_log.delete(); fl_log.delete();
    endtask

    task automatic test_write_single();
        logic [7:0] rd, xd; int lat, n0; exp_t e; wr_ev_t w;
        exp_q.push_back('{d: 8'h00, lat: 3}); out_exp_q.push_back(8'hA5);
        wb_access(1'b1, ADR_DATA, 8'hA5, rd, lat, n0);
        e = exp_q.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL write_ack_latency got %0d exp %0d", lat, e.lat); end
        checks++;
        if (wr_log.size() != 1) begin
            errors++; $display("FAIL write_strobe_count got %0d exp 1", wr_log.size());
        end else begin
            w = wr_log.pop_front(); xd = out_exp_q.pop_front();
            checks++; if (w.n - n0 != 1) begin errors++; $display("FAIL write_strobe_cycle got T+%0d exp T+1", w.n - n0); end
            checks++; if (w.d !== xd) begin errors++; $display("FAIL write_data got %h exp %h", w.d, xd); end
        end
        exp_q.push_back('{d: 8'h04, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_after_write got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
    endtask

    task automatic test_flush();
        logic [7:0] rd; int lat, n0; exp_t e;
        fl_log.delete();
        wb_access(1'b1, ADR_CTRL, 8'h03, rd, lat, n0);
        exp_q.push_back('{d: 8'h03, lat: 1});
        wb_access(1'b0, ADR_CTRL, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL ctrl_readback got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
        wb_access(1'b1, ADR_CTRL, 8'h80, rd, lat, n0);
        checks++; if (lat !== 3) begin errors++; $display("FAIL flush_ack_latency got %0d exp 3", lat); end
        checks++;
        if (fl_log.size() != 2 || fl_log[0] - n0 != 1 || fl_log[1] - n0 != 2) begin
            errors++; $display("FAIL flush_pulse got %0d cycles exp 2 cycles at T+1,T+2", fl_log.size());
        end
        exp_q.push_back('{d: 8'h00, lat: 1});
        wb_access(1'b0, ADR_CTRL, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL ctrl_after_flush got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
        exp_q.push_back('{d: 8'h00, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_after_flush got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rd, xd; int lat, n0; exp_t e; wr_ev_t w;
        wr_log.delete();
        for (int i = 0; i < 8; i++) begin
            out_exp_q.push_back(8'h10 + 8'(i));
            wb_access(1'b1, ADR_DATA, 8'h10 + 8'(i), rd, lat, n0);
            checks++;
            if (lat !== 3 || wr_log.size() != 1) begin
                errors++; $display("FAIL fill_write%0d got lat %0d strobes %0d exp lat 3 strobes 1", i, lat, wr_log.size());
                wr_log.delete(); void'(out_exp_q.pop_front());
            end else begin
                w = wr_log.pop_front(); xd = out_exp_q.pop_front();
                checks++; if (w.d !== xd) begin errors++; $display("FAIL fill_data%0d got %h exp %h", i, w.d, xd); end
            end
        end
        wb_access(1'b1, ADR_DATA, 8'h11, rd, lat, n0);
        checks++;
        if (lat !== 1 || wr_log.size() != 0) begin
            errors++; $display("FAIL overflow_write got lat %0d strobes %0d exp lat 1 strobes 0", lat, wr_log.size());
        end
        exp_q.push_back('{d: 8'h1C, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_overflow got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
        wb_access(1'b1, ADR_CTRL, 8'h40, rd, lat, n0);
        exp_q.push_back('{d: 8'h0C, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_sticky_clear got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
    endtask

    task automatic test_read();
        logic [7:0] rd; int lat, n0; exp_t e;
        logic [7:0] bytes [2];
        bytes[0] = 8'h3C; bytes[1] = 8'h7E;
        rd_log.delete();
        in_push(bytes[0]); in_push(bytes[1]);
        exp_q.push_back('{d: 8'h0D, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_inbound got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{d: bytes[i], lat: 3});
            wb_access(1'b0, ADR_DATA, 8'h00, rd, lat, n0);
            e = exp_q.pop_front();
            checks++;
            if (lat !== e.lat || rd !== e.d) begin
                errors++; $display("FAIL read%0d got lat %0d data %h exp lat %0d data %h", i, lat, rd, e.lat, e.d);
            end
            checks++;
            if (rd_log.size() != 1 || rd_log[0] - n0 != 1) begin
                errors++; $display("FAIL read%0d_strobe got %0d strobes exp 1 at T+1", i, rd_log.size());
            end
            rd_log.delete();
        end
        exp_q.push_back('{d: 8'h00, lat: 1});
        wb_access(1'b0, ADR_DATA, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d || rd_log.size() != 0) begin
            errors++; $display("FAIL underflow_read got lat %0d data %h strobes %0d exp lat %0d data %h strobes 0",
                lat, rd, rd_log.size(), e.lat, e.d);
        end
        exp_q.push_back('{d: 8'h2C, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_underflow got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
    endtask

    task automatic test_irq();
        logic [7:0] rd; int lat, n0;
        wb_access(1'b1, ADR_CTRL, 8'h01, rd, lat, n0);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
        in_push(8'h55);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_rise got %b exp 1", irq); end
        exp_q.push_back('{d: 8'h55, lat: 3});
        wb_access(1'b0, ADR_DATA, 8'h00, rd, lat, n0);
        begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (lat !== e.lat || rd !== e.d) begin
                errors++; $display("FAIL irq_pop_read got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
            end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_fall got %b exp 0", irq); end
        rd_log.delete();
    endtask

    task automatic test_abort();
        logic [7:0] rd; int lat, n0; exp_t e; bit ack_seen;
        wb_access(1'b1, ADR_CTRL, 8'h80, rd, lat, n0);
        wr_log.delete();
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = ADR_DATA; wb.wb_dat_i = 8'h66;
        n0 = pcnt;
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        ack_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (wb.wb_ack_o !== 1'b0) ack_seen = 1'b1;
        end
        checks++; if (ack_seen) begin errors++; $display("FAIL abort_ack got ack exp none"); end
        checks++;
        if (wr_log.size() != 1 || wr_log[0].d !== 8'h66 || wr_log[0].n - n0 != 1) begin
            errors++; $display("FAIL abort_push got %0d strobes exp 1 strobe data 66 at T+1", wr_log.size());
        end
        exp_q.push_back('{d: 8'h24, lat: 1});
        wb_access(1'b0, ADR_STATUS, 8'h00, rd, lat, n0);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || rd !== e.d) begin
            errors++; $display("FAIL status_after_abort got lat %0d data %h exp lat %0d data %h", lat, rd, e.lat, e.d);
        end
        wr_log.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, b, xd; int lat, n0, prev_n;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            out_exp_q.push_back(b);
            wb_access(1'b1, ADR_DATA, b, rd, lat, n0);
            checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_lat%0d got %0d exp 3", i, lat); end
        end
        checks++;
        if (wr_log.size() != 4) begin
            errors++; $display("FAIL b2b_strobe_count got %0d exp 4", wr_log.size());
        end else begin
            prev_n = -100;
            for (int i = 0; i < 4; i++) begin
                xd = out_exp_q.pop_front();
                checks++;
                if (wr_log[i].d !== xd || wr_log[i].n - prev_n < 3) begin
                    errors++; $display("FAIL b2b_data%0d got %h gap %0d exp %h gap>=3", i, wr_log[i].d, wr_log[i].n - prev_n, xd);
                end
                prev_n = wr_log[i].n;
            end
        end
        checks++; if (both_hi != 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", both_hi); end
    endtask

    initial begin
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
        reset_n = 1'b0;
        test_reset();
        test_write_single();
        test_flush();
        test_overflow();
        test_read();
        test_irq();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
